// File: rtl/cmp_search.sv
// Successive-approximation controller: binary-searches an unknown A by driving
// guesses to a G/L/E comparator. Optional watchdog: CMP_SEARCH_TIMEOUT_EN.
module cmp_search #(
   parameter int WIDTH   = 3,
   parameter int STEP_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              req,
   output logic [WIDTH-1:0]  guess,
   input  logic              cmp_valid,
   input  logic              G,
   input  logic              L,
   input  logic              E,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [WIDTH-1:0]  result,
   output logic [STEP_W-1:0] steps
);

   typedef enum logic [2:0] {IDLE, QUERY, UPDATE, DONE, ERR} state_t;

   // lo/hi carry one extra bit so guess+1 at the top never wraps
   localparam logic [WIDTH:0]   HI_INIT = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH-1:0] G_MAX   = {WIDTH{1'b1}};

   state_t            state, state_n;
   logic [WIDTH:0]    lo, lo_n, hi, hi_n, mid;
   logic [WIDTH-1:0]  guess_n, result_n;
   logic [STEP_W-1:0] steps_n, steps_inc;

`ifdef CMP_SEARCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wdog, wdog_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         lo     <= '0;
         hi     <= HI_INIT;
         guess  <= '0;
         result <= '0;
         steps  <= '0;
`ifdef CMP_SEARCH_TIMEOUT_EN
         wdog   <= '0;
`endif
      end else begin
         state  <= state_n;
         lo     <= lo_n;
         hi     <= hi_n;
         guess  <= guess_n;
         result <= result_n;
         steps  <= steps_n;
`ifdef CMP_SEARCH_TIMEOUT_EN
         wdog   <= wdog_n;
`endif
      end
   end

   assign mid       = lo + hi;
   assign steps_inc = (steps == {STEP_W{1'b1}}) ? steps : steps + 1'b1;

   always_comb begin
      state_n  = state;
      lo_n     = lo;
      hi_n     = hi;
      guess_n  = guess;
      result_n = result;
      steps_n  = steps;
`ifdef CMP_SEARCH_TIMEOUT_EN
      wdog_n   = wdog;
`endif
      case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               lo_n    = '0;
               hi_n    = HI_INIT;
               guess_n = HI_INIT[WIDTH:1];
               steps_n = '0;
               state_n = QUERY;
`ifdef CMP_SEARCH_TIMEOUT_EN
               wdog_n  = '0;
`endif
            end
         end
         QUERY: begin
            if (cmp_valid) begin
               steps_n = steps_inc;
               if (!$onehot({G, L, E})) begin
                  state_n = ERR;
               end else if (E) begin
                  result_n = guess;
                  state_n  = DONE;
               end else if (G) begin
                  if (guess == G_MAX) state_n = ERR;
                  else begin
                     lo_n    = {1'b0, guess} + 1'b1;
                     state_n = UPDATE;
                  end
               end else begin
                  if (guess == '0) state_n = ERR;
                  else begin
                     hi_n    = {1'b0, guess} - 1'b1;
                     state_n = UPDATE;
                  end
               end
            end
`ifdef CMP_SEARCH_TIMEOUT_EN
            else if (wdog == TW'(TIMEOUT - 1)) state_n = ERR;
            else wdog_n = wdog + 1'b1;
`endif
         end
         UPDATE: begin
            if (lo > hi) state_n = ERR;
            else begin
               guess_n = mid[WIDTH:1];
               state_n = QUERY;
`ifdef CMP_SEARCH_TIMEOUT_EN
               wdog_n  = '0;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // status decoded from state so an async reset clears them at once
   assign req  = (state == QUERY);
   assign busy = (state == QUERY) || (state == UPDATE);
   assign done = (state == DONE);
   assign err  = (state == ERR);

endmodule

// File: tb/tb_cmp_search.sv
// Directed bench for cmp_search: ideal comparator responder with a flag-fault
// override, checked with immediate assertions.
module tb_cmp_search;
   localparam int WIDTH = 3, STEP_W = 4, TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              req, busy, done, err;
   logic [WIDTH-1:0]  guess, result;
   logic [STEP_W-1:0] steps;
   logic              cmp_valid = 1'b1;
   logic              G, L, E;
   logic [WIDTH-1:0]  a_val = '0;
   logic              force_bad = 1'b0;
   int                checks = 0;
   int                errors = 0;

   cmp_search #(.WIDTH(WIDTH), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .req(req), .guess(guess),
      .cmp_valid(cmp_valid), .G(G), .L(L), .E(E), .busy(busy), .done(done),
      .err(err), .result(result), .steps(steps)
   );

   always #5 clk = ~clk;

   always_comb begin
      G = force_bad ? 1'b1 : (a_val > guess);
      L = force_bad ? 1'b1 : (a_val < guess);
      E = force_bad ? 1'b0 : (a_val == guess);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one active edge, then sample on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // expects to be in QUERY with guess g; consumes the answer (and UPDATE if not last)
   task automatic query(input string tag, input logic [WIDTH-1:0] g, input bit last);
      chk({tag, "_req"}, req, 1);
      chk({tag, "_guess"}, guess, g);
      step();
      if (!last) begin
         chk({tag, "_upd"}, {req, busy}, 2'b01);
         step();
      end
   endtask

   initial begin
      bit req_dropped;
      // reset state
      #12;
      chk("rst_flags", {req, busy, done, err}, 4'b0000);
      chk("rst_guess", guess, 0);
      chk("rst_result", result, 0);
      chk("rst_steps", steps, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("idle_wait", {req, busy}, 2'b00);

      // A=5: 3(G), 5(E); done 3 edges after the edge that samples start
      a_val = 5;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("a5_busy", busy, 1);
      query("a5_q0", 3'd3, 0);
      chk("a5_notdone", done, 0);
      query("a5_q1", 3'd5, 1);
      chk("a5_done", {done, err, busy, req}, 4'b1000);
      chk("a5_result", result, 5);
      chk("a5_steps", steps, 2);
      step();
      chk("a5_hold", done, 1);

      // A=0 restarted from DONE; start during a QUERY answer is ignored
      a_val = 0;
      start = 1'b1;
      step();
      chk("a0_donecl", done, 0);
      query("a0_q0", 3'd3, 0);
      start = 1'b0;
      query("a0_q1", 3'd1, 0);
      query("a0_q2", 3'd0, 1);
      chk("a0_done", done, 1);
      chk("a0_result", result, 0);
      chk("a0_steps", steps, 3);

      // A=7 worst case: WIDTH+1 queries
      a_val = 7;
      start = 1'b1;
      step();
      start = 1'b0;
      query("a7_q0", 3'd3, 0);
      query("a7_q1", 3'd5, 0);
      query("a7_q2", 3'd6, 0);
      query("a7_q3", 3'd7, 1);
      chk("a7_done", done, 1);
      chk("a7_result", result, 7);
      chk("a7_steps", steps, 4);

      // G and L both set on the first answer
      force_bad = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      query("bad_q0", 3'd3, 1);
      chk("bad_flags", {err, done, busy, req}, 4'b1000);
      chk("bad_steps", steps, 1);
      force_bad = 1'b0;
      a_val = 6;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_guess", guess, 3);
      chk("restart_err", err, 0);

      // reset while in QUERY (guess=5) with A=6
      query("rq_q0", 3'd3, 0);
      chk("rq_guess", guess, 5);
      rst_n = 1'b0;
      #1;
      chk("rq_rst", {req, busy, done, err}, 4'b0000);
      chk("rq_guess0", guess, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      chk("rq_idle", {req, busy, done, err}, 4'b0000);
      start = 1'b1;
      step();
      start = 1'b0;
      query("a6_q0", 3'd3, 0);
      query("a6_q1", 3'd5, 0);
      query("a6_q2", 3'd6, 1);
      chk("a6_done", done, 1);
      chk("a6_result", result, 6);
      chk("a6_steps", steps, 3);

      // comparator never answers
      cmp_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("to_req", req, 1);
`ifdef CMP_SEARCH_TIMEOUT_EN
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      chk("to_pre", {err, req}, 2'b01);
      step();
      chk("to_err", {err, req, busy}, 3'b100);
      chk("to_steps", steps, 0);
`else
      req_dropped = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!req || err) req_dropped = 1'b1;
      end
      chk("to_wait", req_dropped, 0);
      chk("to_noerr", err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
